// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow for a single bit position.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - b_in LSB first, one bit per clock,
// publishing diff/b_out only once the whole word has been processed.
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  logic               load, step, finish;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic               br_q;
  logic               bit_d, br_nxt;

  full_subtractor u_fs (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .br_in  (br_q),
    .d      (bit_d),
    .br_out (br_nxt)
  );

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with status flags registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ST_RUN);
      done    <= (state_d == ST_DONE);
    end
  end

  // Operand/result shift registers; diff only changes on the final bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff   <= '0;
      b_out  <= 1'b0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      br_q   <= b_in;
      res_sr <= '0;
      cnt_q  <= '0;
    end else if (step) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= {bit_d, res_sr[WIDTH-1:1]};
      br_q   <= br_nxt;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (finish) begin
        diff  <= {bit_d, res_sr[WIDTH-1:1]};
        b_out <= br_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         b_in;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         b_out;

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge, then scramble operands to prove they were latched
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    a = av; b = bv; b_in = bi; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
  endtask

  // Wait (bounded) for done; n0 = edges already elapsed since the accepting edge
  task automatic wait_done(input string tag, input int n0, input bit chk_busy,
                           input logic [W-1:0] prev_diff);
    int n;
    n = n0;
    while (done !== 1'b1 && n < 40) begin
      if (chk_busy) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_diff_hold"}, 32'(diff), 32'(prev_diff));
      end
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(W));
    if (chk_busy) check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic count_dones(input string tag, input int cycles, input int exp);
    int c;
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done === 1'b1) c++;
      tick();
    end
    check(tag, 32'(c), 32'(exp));
  endtask

  initial begin
    logic [W:0] e;
    int gap;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    tick(); tick();
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_diff",  32'(diff),  32'd0);
    check("rst_b_out", 32'(b_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // 7 - 3 - 0
    start_op(4'd7, 4'd3, 1'b0);
    wait_done("op7_3", 0, 1'b1, 4'd0);
    check("op7_3_diff", 32'(diff), 32'd4);
    check("op7_3_bout", 32'(b_out), 32'd0);
    tick();
    check("op7_3_done_pulse", 32'(done), 32'd0);
    tick();

    // 3 - 7 - 0 and 0 - 0 - 1
    start_op(4'd3, 4'd7, 1'b0);
    wait_done("op3_7", 0, 1'b1, 4'd4);
    check("op3_7_diff", 32'(diff), 32'd12);
    check("op3_7_bout", 32'(b_out), 32'd1);
    tick();
    start_op(4'd0, 4'd0, 1'b1);
    wait_done("op0_0_1", 0, 1'b1, 4'd12);
    check("op0_0_1_diff", 32'(diff), 32'd15);
    check("op0_0_1_bout", 32'(b_out), 32'd1);
    tick(); tick();

    // start re-pulsed during RUN is ignored
    start_op(4'd9, 4'd2, 1'b0);
    tick();
    a = 4'd1; b = 4'd1; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("op9_2", 2, 1'b1, 4'd15);
    check("op9_2_diff", 32'(diff), 32'd7);
    check("op9_2_bout", 32'(b_out), 32'd0);
    tick();
    count_dones("op9_2_single_done", 8, 0);

    // reset in the 2nd RUN cycle aborts
    start_op(4'd9, 4'd2, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_diff",  32'(diff),  32'd0);
    check("abort_b_out", 32'(b_out), 32'd0);
    count_dones("abort_no_done", 8, 0);
    start_op(4'd5, 4'd2, 1'b0);
    wait_done("op5_2", 0, 1'b1, 4'd0);
    check("op5_2_diff", 32'(diff), 32'd3);
    tick();

    // reset wins over start on the same edge
    a = 4'd6; b = 4'd1; b_in = 1'b0; start = 1'b1; rst_n = 1'b0;
    tick();
    start = 1'b0; rst_n = 1'b1;
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_diff", 32'(diff), 32'd0);
    tick();

    // back-to-back: start held in the DONE cycle
    start_op(4'd8, 4'd1, 1'b0);
    wait_done("op8_1", 0, 1'b1, 4'd0);
    check("op8_1_diff", 32'(diff), 32'd7);
    start_op(4'd2, 4'd5, 1'b0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    wait_done("op2_5", 0, 1'b1, 4'd7);
    check("op2_5_diff", 32'(diff), 32'd13);
    check("op2_5_bout", 32'(b_out), 32'd1);
    tick();

    // exhaustive sweep with random done-to-start gap
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          e = (W+1)'(ai) - (W+1)'(bi) - (W+1)'(ci);
          start_op(W'(ai), W'(bi), 1'(ci));
          wait_done("sweep", 0, 1'b0, 4'd0);
          check($sformatf("sweep_%0d_%0d_%0d", ai, bi, ci), 32'({b_out, diff}), 32'(e));
          gap = int'($urandom_range(0, 3));
          for (int g = 0; g < gap; g++) tick();
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled each rising edge.
REQ-005 a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-007 b_in  input  1  borrow-in; sampled only on the edge that accepts start.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  single-cycle pulse when the result is complete.
REQ-010 diff  output  WIDTH  registered result, a - b - b_in modulo 2^WIDTH.
REQ-011 b_out  output  1  registered borrow-out; 1 when a < b + b_in (unsigned).

Function
REQ-012 FSM states IDLE, RUN, DONE; one-hot or binary encoding is free.
REQ-013 IDLE or DONE with start=1 at an edge: latch a, b, b_in; clear the bit counter; go to RUN; the start is "accepted".
REQ-014 IDLE with start=0: stay IDLE; DONE with start=0: go to IDLE after one cycle.
REQ-015 RUN: each edge processes one bit, LSB first: d_i = a_i ^ b_i ^ br; br' = (~a_i & b_i) | (~(a_i ^ b_i) & br); br is initialised from b_in.
REQ-016 RUN lasts exactly WIDTH edges; the edge that processes bit WIDTH-1 moves to DONE.
REQ-017 Latency: start accepted at edge k -> busy=1 for the cycles following edges k..k+WIDTH-1; done=1 for exactly the cycle following edge k+WIDTH.
REQ-018 diff and b_out update only on the edge entering DONE; they hold their values until the next transition into DONE or reset. Partial results are never visible on diff.
REQ-019 start while in RUN is ignored; the operands in flight are unaffected.
REQ-020 start in the DONE cycle is accepted (back-to-back operation); done pulses and busy rises in the next cycle; diff keeps the prior result until the new DONE.
REQ-021 busy and done are never high in the same cycle.
REQ-022 Changes on a, b or b_in outside the accepting edge have no effect.

Reset
REQ-023 rst_n=0 at an edge forces IDLE, busy=0, done=0, diff=0, b_out=0, and clears the counter and internal shift registers.
REQ-024 Reset during RUN aborts the operation; no done pulse follows; the first post-reset start behaves as from power-up.
REQ-025 Reset takes priority over start on the same edge.

Structure
REQ-026 Shared package subtractor_pkg holds the FSM state encodings and the default WIDTH constant.
REQ-027 The one-bit difference/borrow logic is a sub-module full_subtractor (ports a, b, br_in, d, br_out), instantiated once and reused each cycle.
REQ-028 The operand shift registers, the result shift register, the counter ($clog2(WIDTH)+1 bits) and the FSM live in serial_subtractor.

Verification
REQ-029 WIDTH=4, a=7, b=3, b_in=0, start one cycle -> busy high 4 cycles, then done pulse; diff=4, b_out=0.
REQ-030 a=3, b=7, b_in=0 -> diff=12 (4'b1100), b_out=1; a=0, b=0, b_in=1 -> diff=15, b_out=1.
REQ-031 Start accepted with a=9, b=2; start re-pulsed with a=1, b=1 in the 2nd RUN cycle -> single done, diff=7, b_out=0.
REQ-032 rst_n low in the 2nd RUN cycle -> next cycle busy=0, done=0, diff=0, b_out=0; no done pulse; a subsequent 5-2 gives diff=3.
REQ-033 start held in the DONE cycle of 8-1 with a=2, b=5 -> diff=7 at the first done; busy rises immediately; diff=13, b_out=1 at the second done, 4 cycles later.
REQ-034 Exhaustive check of all 512 (a, b, b_in) combinations against a - b - b_in, with the done-to-start gap randomised between 0 and 3 cycles.
